// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state and add/sub mode encodings for the ALU slices
package alu_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder built from full-adder cells
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (b[i] & c[i]) | (c[i] & a[i]);
  end
  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/sub, CHUNK bits per cycle with a start/busy/done handshake.
// Defining SEQ_ADDSUB_FLAGS_EN adds registered zero/neg/ovf flag outputs.
module seq_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SEQ_ADDSUB_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, sum_nx;
  logic [IW-1:0]    idx;
  logic             carry, co_c, c_msb;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  always_comb begin
    a_c = '0;
    b_c = '0;
    sum_nx = sum;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_c = op_a[i*CHUNK +: CHUNK];
        b_c = op_b[i*CHUNK +: CHUNK];
        sum_nx[i*CHUNK +: CHUNK] = s_c;
      end
    end
  end
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a(a_c), .b(b_c), .ci(carry), .s(s_c), .co(co_c), .c_msb_in(c_msb)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
`ifdef SEQ_ADDSUB_FLAGS_EN
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_a  <= inA;
          op_b  <= sub == OP_SUB ? ~inB : inB;
          carry <= sub == OP_SUB ? 1'b1 : cin;
          idx   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          sum   <= sum_nx;
          carry <= co_c;
          idx   <= idx + 1'b1;
          if (idx == IW'(NCHUNK - 1)) begin
            cout  <= co_c;
            busy  <= 1'b0;
            state <= DONE;
`ifdef SEQ_ADDSUB_FLAGS_EN
            zero  <= sum_nx == '0;
            neg   <= sum_nx[WIDTH-1];
            ovf   <= c_msb ^ co_c;
`endif
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifndef SEQ_ADDSUB_FLAGS_EN
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed checks of seq_addsub with CHUNK=2 and CHUNK=8 instances
module tb_seq_addsub;
  logic       clk = 0, rst = 1, start = 0, start8 = 0, sub = 0, cin = 0;
  logic [7:0] inA = 0, inB = 0;
  logic       busy, done, cout, busy8, done8, cout8;
  logic [7:0] sum, sum8;
`ifdef SEQ_ADDSUB_FLAGS_EN
  logic       zero, neg, ovf, zero8, neg8, ovf8;
`endif
  int passed = 0, total = 0, ndone;
  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .inA(inA), .inB(inB), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef SEQ_ADDSUB_FLAGS_EN
    .zero(zero), .neg(neg), .ovf(ovf),
`endif
    .cout(cout)
  );
  seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub), .inA(inA), .inB(inB), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8),
`ifdef SEQ_ADDSUB_FLAGS_EN
    .zero(zero8), .neg(neg8), .ovf(ovf8),
`endif
    .cout(cout8)
  );

  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci);
    inA = a; inB = b; sub = s; cin = ci; start = 1;
    step();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      chk("busy_run", {8'd0, busy}, 9'd1);
      chk("done_run", {8'd0, done}, 9'd0);
      step();
    end
    chk("busy_last", {8'd0, busy}, 9'd0);
    chk("done_early", {8'd0, done}, 9'd0);
    step();
    chk("done_pulse", {8'd0, done}, 9'd1);
    chk("busy_done", {8'd0, busy}, 9'd0);
    step();
    chk("done_once", {8'd0, done}, 9'd0);
  endtask

  initial begin
    step(); step();
    chk("rst_busy", {8'd0, busy}, 9'd0);
    chk("rst_done", {8'd0, done}, 9'd0);
    chk("rst_sum", {1'b0, sum}, 9'd0);
    chk("rst_cout", {8'd0, cout}, 9'd0);
    rst = 0;
    op2(8'h5A, 8'h33, 0, 0);
    chk("add1", {cout, sum}, 9'h08D);
`ifdef SEQ_ADDSUB_FLAGS_EN
    chk("add1_ovf", {8'd0, ovf}, 9'd1);
    chk("add1_zero", {8'd0, zero}, 9'd0);
`endif
    op2(8'hFF, 8'h00, 0, 1);
    chk("add_cin", {cout, sum}, 9'h100);
`ifdef SEQ_ADDSUB_FLAGS_EN
    chk("addc_zero", {8'd0, zero}, 9'd1);
    chk("addc_ovf", {8'd0, ovf}, 9'd0);
`endif
    op2(8'h10, 8'h20, 1, 1);
    chk("sub_borrow", {cout, sum}, 9'h0F0);
`ifdef SEQ_ADDSUB_FLAGS_EN
    chk("sub_neg", {8'd0, neg}, 9'd1);
    chk("sub_ovf", {8'd0, ovf}, 9'd0);
`endif
    op2(8'h20, 8'h10, 1, 0);
    chk("sub_ok", {cout, sum}, 9'h110);
    repeat (3) step();
    chk("hold_sum", {cout, sum}, 9'h110);
    // second start mid-RUN with a different operand must be ignored
    inA = 8'h7F; inB = 8'h01; sub = 0; cin = 0; start = 1;
    step();
    start = 0;
    step();
    inA = 8'h00; start = 1;
    step();
    start = 0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) ndone++;
      step();
    end
    chk("ign_ndone", 9'(ndone), 9'd1);
    chk("ign_sum", {cout, sum}, 9'h080);
`ifdef SEQ_ADDSUB_FLAGS_EN
    chk("ign_ovf", {8'd0, ovf}, 9'd1);
    chk("ign_neg", {8'd0, neg}, 9'd1);
`endif
    // reset in the middle of an op aborts it without a done pulse
    inA = 8'hAA; inB = 8'h55; start = 1;
    step();
    start = 0;
    step();
    chk("abort_busy_pre", {8'd0, busy}, 9'd1);
    rst = 1;
    step();
    rst = 0;
    chk("abort_busy", {8'd0, busy}, 9'd0);
    chk("abort_sum", {cout, sum}, 9'h000);
    ndone = 0;
    for (int k = 0; k < 7; k++) begin
      if (done) ndone++;
      step();
    end
    chk("abort_ndone", 9'(ndone), 9'd0);
    op2(8'h01, 8'h01, 0, 0);
    chk("after_abort", {cout, sum}, 9'h002);
    // single-chunk instance: one RUN cycle, done two edges after accept
    inA = 8'hC8; inB = 8'h64; sub = 0; cin = 0; start8 = 1;
    step();
    start8 = 0;
    chk("c8_busy", {8'd0, busy8}, 9'd1);
    chk("c8_done0", {8'd0, done8}, 9'd0);
    step();
    chk("c8_busy1", {8'd0, busy8}, 9'd0);
    chk("c8_done1", {8'd0, done8}, 9'd0);
    step();
    chk("c8_done2", {8'd0, done8}, 9'd1);
    chk("c8_sum", {cout8, sum8}, 9'h12C);
    chk("main_idle", {8'd0, busy}, 9'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor and the next generation of the ALU's 1-bit adder cell.
- Adds or subtracts WIDTH-bit operands CHUNK bits per cycle, holding the inter-chunk carry in a register.
- Uses a start/busy/done handshake so wide ALU slices can trade latency for area.
- Sits between the ALU operand registers and the result mux.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK, WIDTH/CHUNK, derived (localparam); number of compute cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = inA+inB+cin; 1 = inA−inB (cin ignored).
- inA  input  WIDTH  operand A; captured on accepted start.
- inB  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in for add mode.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when sum/cout are valid.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow.

Behaviour:
- Reset: clock and reset are named clk and rst, reset synchronous and active-high. On rst=1 at a rising edge: state=IDLE, busy=0, done=0, sum=0, cout=0, internal carry/index/operand regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: accept the request.
  - Latch opA=inA and opB = sub ? ~inB : inB.
  - Carry reg = sub ? 1 : cin.
  - idx=0, busy=1, go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) = opA chunk + opB chunk + carry.
  - Write chunk result into sum, update carry, idx++.
  - When idx=NCHUNK−1 this cycle: cout←final carry, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start during DONE is ignored; the earliest accept is the next IDLE cycle.
- Latency:
  - Start accepted at edge 0; busy=1 from edge 0 through edge NCHUNK.
  - done=1 after edge NCHUNK+1 for one cycle.
  - Throughput: one op per NCHUNK+2 cycles.
- sum bits update chunk-by-chunk during RUN and are not valid until done. After done, sum/cout hold until the next accepted start.
- start while busy or in DONE: ignored, no effect on the in-flight op.
- Input changes after acceptance do not affect the result.
- CHUNK=WIDTH: NCHUNK=1, single RUN cycle.
- Arithmetic is modulo 2^WIDTH; no saturation.
- rst mid-operation: immediate return to IDLE with reset values; no done pulse for the aborted op.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro: SEQ_ADDSUB_FLAGS_EN.
- When defined, add output ports zero(1), neg(1), ovf(1), registered with cout in the same cycle.
  - zero = (sum==0).
  - neg = sum[WIDTH−1].
  - ovf = two's-complement overflow, i.e. carry into MSB XOR carry out of MSB, computed in the final chunk.
  - All three reset to 0 and hold like sum.
- When undefined, the ports do not exist and no flag logic is generated.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - mode constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: chunk_adder (parameter CHUNK), purely combinational ripple adder.
  - Ports a, b, ci; outputs s, co, plus c_msb_in for overflow.
  - Built from per-bit sum=a^b^c, carry=ab+bc+ca cells.
  - Instantiated once; seq_addsub muxes the operand chunk by idx.

Test Plan:
- WIDTH=8, CHUNK=2, add 0x5A+0x33, cin=0 -> busy 4 cycles, done pulse 1 cycle, sum=0x8D, cout=0, ovf=1 (flags build).
- Add 0xFF+0x00, cin=1 -> sum=0x00, cout=1, zero=1, ovf=0.
- sub=1, 0x10−0x20 -> sum=0xF0, cout=0 (borrow), neg=1, ovf=0; then 0x20−0x10 -> sum=0x10, cout=1.
- Add 0x7F+0x01 -> sum=0x80, ovf=1, neg=1. Pulse start=1 again at RUN cycle 2 with inA=0x00 -> ignored, result unchanged, only one done.
- Start 0xAA+0x55, assert rst at RUN cycle 2 -> next cycle busy=0, sum=0, cout=0, no done. Then new op 0x01+0x01 completes with sum=0x02.
- CHUNK=8 (NCHUNK=1): 0xC8+0x64 -> done 2 cycles after start, sum=0x2C, cout=1.
